// File: rtl/trap_pkg.sv
// Shared definitions for trap sequencing: FSM states, mtvec modes, cause widths
// and machine-mode interrupt cause codes.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_REDIRECT,
        ST_SLEEP
    } trap_state_e;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    localparam int CAUSE_W = 5;

    localparam logic [3:0] IRQ_M_EXT   = 4'd11;
    localparam logic [3:0] IRQ_M_TIMER = 4'd7;
    localparam logic [3:0] IRQ_M_SOFT  = 4'd3;

endpackage

// File: rtl/trap_vector_calc.sv
// Combinational trap target from mtvec: the base address, or base + 4*cause for
// interrupts in vectored mode. Also used by the csr block.
module trap_vector_calc
    import trap_pkg::*;
(
    input  logic [31:0] mtvec,
    input  logic        interupt,
    input  logic [3:0]  ecause,
    output logic [31:0] target
);

    logic [31:0] base;

    assign base = {mtvec[31:2], 2'b00};

    // Any mode other than vectored (including the reserved ones) jumps to base.
    assign target = (mtvec[1:0] == MTVEC_VECTORED && interupt)
                  ? base + {26'd0, ecause, 2'b00}
                  : base;

endmodule

// File: rtl/trap_sequencer.sv
// Sequences flush/stall, CSR commit pulses and the fetch redirect around
// writeback trap, mret and wfi events; owns the machine-mode sleep state.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               traped,
    input  logic               interupt,
    input  logic [3:0]         ecause,
    input  logic [31:0]        ecp,
    input  logic               mret,
    input  logic               wfi,
    input  logic               irq_pending,
    input  logic [31:0]        mtvec,
    input  logic [31:0]        mepc,
    input  logic               redirect_ready,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               flush,
    output logic               stall,
    output logic               trap_commit,
    output logic               mret_commit,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic [31:0]        trap_epc,
    output logic               busy
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    trap_state_e state;
    logic [3:0]  flush_cnt;
    logic [31:0] target;
    logic [31:0] vec_target;

    trap_vector_calc u_vector (
        .mtvec    (mtvec),
        .interupt (interupt),
        .ecause   (ecause),
        .target   (vec_target)
    );

    // NOTE: all state and outputs update with <= so every branch reads the
    // pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            flush_cnt      <= '0;
            target         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            stall          <= 1'b0;
            trap_commit    <= 1'b0;
            mret_commit    <= 1'b0;
            trap_cause     <= '0;
            trap_epc       <= '0;
            busy           <= 1'b0;
        end else begin
            trap_commit <= 1'b0;
            mret_commit <= 1'b0;

            case (state)
                ST_RUN: begin
                    if (traped || mret) begin
                        if (traped) begin
                            trap_epc    <= ecp;
                            trap_cause  <= {interupt, ecause};
                            target      <= vec_target;
                            trap_commit <= 1'b1;
                        end else begin
                            target      <= mepc;
                            mret_commit <= 1'b1;
                        end
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        flush     <= 1'b1;
                        stall     <= 1'b1;
                        busy      <= 1'b1;
                    end else if (wfi && !irq_pending) begin
                        state <= ST_SLEEP;
                        stall <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                ST_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state          <= ST_REDIRECT;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end

                // redirect_pc stays frozen until fetch accepts it.
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= ST_RUN;
                        redirect_valid <= 1'b0;
                        stall          <= 1'b0;
                        busy           <= 1'b0;
                    end
                end

                ST_SLEEP: begin
                    if (irq_pending) begin
                        state <= ST_RUN;
                        stall <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state          <= ST_RUN;
                    flush          <= 1'b0;
                    stall          <= 1'b0;
                    busy           <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed vector table, multi-cycle
// corner sequences and randomized events against a behavioural model.
module tb_trap_sequencer;
    import trap_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        traped, interupt, mret, wfi, irq_pending, redirect_ready;
    logic [3:0]  ecause;
    logic [31:0] ecp, mtvec, mepc;
    logic        redirect_valid, flush, stall, trap_commit, mret_commit, busy;
    logic [31:0] redirect_pc, trap_epc;
    logic [4:0]  trap_cause;

    int total = 0;
    int bad   = 0;

    // Model of the CSR-facing trap registers: last trap cause and EPC.
    logic [4:0]  m_cause;
    logic [31:0] m_epc;

    typedef struct {
        logic        t;
        logic        intr;
        logic [3:0]  ec;
        logic [31:0] pc;
        logic [31:0] tv;
        logic [31:0] ep;
        logic        m;
        int          delay;
        logic [31:0] exp_pc;
        logic [4:0]  exp_cause;
    } vec_t;

    vec_t tbl[8];

    trap_sequencer #(.FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .traped         (traped),
        .interupt       (interupt),
        .ecause         (ecause),
        .ecp            (ecp),
        .mret           (mret),
        .wfi            (wfi),
        .irq_pending    (irq_pending),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .redirect_ready (redirect_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .stall          (stall),
        .trap_commit    (trap_commit),
        .mret_commit    (mret_commit),
        .trap_cause     (trap_cause),
        .trap_epc       (trap_epc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] tv, input logic intr,
                                                 input logic [3:0] cause);
        longint unsigned base;
        base = longint'(tv) - longint'(tv % 4);
        if ((tv % 4) == 1 && intr)
            return 32'((base + longint'(cause) * 4) % 64'h1_0000_0000);
        return 32'(base);
    endfunction

    task automatic idle_inputs();
        traped = 0; interupt = 0; mret = 0; wfi = 0; irq_pending = 0;
        redirect_ready = 0; ecause = 0; ecp = 0; mtvec = 0; mepc = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rv"},    redirect_valid, 0);
        check({tag, "_rpc"},   redirect_pc, 0);
        check({tag, "_flush"}, flush, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_tc"},    trap_commit, 0);
        check({tag, "_mc"},    mret_commit, 0);
        check({tag, "_cause"}, trap_cause, 0);
        check({tag, "_epc"},   trap_epc, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    // One trap/mret event from RUN through flush, redirect and back to RUN.
    task automatic do_event(input logic t, input logic intr, input logic [3:0] ec,
                            input logic [31:0] pc, input logic [31:0] tv, input logic [31:0] ep,
                            input logic m, input int delay, input logic hold,
                            input logic [31:0] exp_pc, input logic [4:0] exp_cause);
        if (t) begin
            m_cause = exp_cause;
            m_epc   = pc;
        end
        @(negedge clk);
        traped = t; interupt = intr; ecause = ec; ecp = pc; mtvec = tv; mepc = ep;
        mret = m; wfi = 1'($urandom_range(0, 1)); redirect_ready = 0;
        check("idle_busy", busy, 0);
        @(negedge clk);
        check("trap_commit", trap_commit, t);
        check("mret_commit", mret_commit, !t);
        check("flush_first", flush, 1);
        check("stall_first", stall, 1);
        check("busy_first",  busy, 1);
        check("rv_first",    redirect_valid, 0);
        check("cause", trap_cause, m_cause);
        check("epc",   trap_epc, m_epc);
        if (hold) begin
            ecp = $urandom; ecause = 4'($urandom); mepc = $urandom; mtvec = $urandom;
            interupt = 1'($urandom_range(0, 1));
        end else begin
            traped = 0; mret = 0; wfi = 0;
        end
        for (int i = 1; i < FC; i++) begin
            @(negedge clk);
            check("flush_hold", flush, 1);
            check("commit_once", {30'd0, trap_commit, mret_commit}, 0);
            check("rv_in_flush", redirect_valid, 0);
        end
        @(negedge clk);
        for (int j = 0; j <= delay; j++) begin
            check("rv", redirect_valid, 1);
            check("redirect_pc", redirect_pc, exp_pc);
            check("flush_redir", flush, 0);
            check("stall_redir", stall, 1);
            check("busy_redir", busy, 1);
            check("commit_redir", {30'd0, trap_commit, mret_commit}, 0);
            if (j == delay) redirect_ready = 1;
            @(negedge clk);
        end
        check("busy_back", busy, 0);
        check("rv_back", redirect_valid, 0);
        check("stall_back", stall, 0);
        check("cause_kept", trap_cause, m_cause);
        check("epc_kept", trap_epc, m_epc);
        traped = 0; mret = 0; wfi = 0; redirect_ready = 0;
    endtask

    task automatic sleep_seq(input int n);
        @(negedge clk);
        traped = 0; mret = 0; wfi = 1; irq_pending = 0;
        check("pre_sleep_busy", busy, 0);
        @(negedge clk);
        wfi = 0;
        check("sleep_stall", stall, 1);
        check("sleep_busy", busy, 1);
        check("sleep_flush", flush, 0);
        for (int i = 0; i < n; i++) begin
            traped = 1; mret = 1;
            @(negedge clk);
            check("sleep_hold", {29'd0, busy, stall, flush}, 3'b110);
            check("sleep_no_commit", {30'd0, trap_commit, mret_commit}, 0);
        end
        traped = 0; mret = 0; irq_pending = 1;
        @(negedge clk);
        check("wake_busy", busy, 0);
        check("wake_stall", stall, 0);
        wfi = 1;
        @(negedge clk);
        check("wfi_irq_noop", {30'd0, busy, stall}, 0);
        wfi = 0; irq_pending = 0;
    endtask

    initial begin
        logic [31:0] r_tv, r_pc, r_ep;
        logic [3:0]  r_ec;
        logic        r_intr, r_t, r_m;
        logic [3:0]  irq_codes[3];

        irq_codes[0] = IRQ_M_EXT; irq_codes[1] = IRQ_M_TIMER; irq_codes[2] = IRQ_M_SOFT;

        tbl[0] = '{1'b1, 1'b0, 4'd2,  32'h100, 32'h8000_0000, 32'h0,   1'b0, 0, 32'h8000_0000, 5'h02};
        tbl[1] = '{1'b1, 1'b1, 4'd7,  32'h2000, 32'h8000_0001, 32'h0,  1'b0, 0, 32'h8000_001C, 5'h17};
        tbl[2] = '{1'b1, 1'b0, 4'd5,  32'h300, 32'h0000_0100, 32'h204, 1'b1, 1, 32'h0000_0100, 5'h05};
        tbl[3] = '{1'b0, 1'b1, 4'd7,  32'h0,   32'h8000_0001, 32'h204, 1'b1, 3, 32'h0000_0204, 5'h00};
        tbl[4] = '{1'b1, 1'b0, 4'd11, 32'h44,  32'h0000_1001, 32'h0,   1'b0, 0, 32'h0000_1000, 5'h0B};
        tbl[5] = '{1'b1, 1'b1, 4'd15, 32'h48,  32'hFFFF_FFF1, 32'h0,   1'b0, 2, 32'h0000_002C, 5'h1F};
        tbl[6] = '{1'b1, 1'b1, 4'd3,  32'h50,  32'h0000_0403, 32'h0,   1'b0, 0, 32'h0000_0400, 5'h13};
        tbl[7] = '{1'b1, 1'b1, 4'd11, 32'h54,  32'h0000_1001, 32'h0,   1'b0, 0, 32'h0000_102C, 5'h1B};

        idle_inputs();
        m_cause = 0; m_epc = 0;
        rst_n = 0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 8; i++)
            do_event(tbl[i].t, tbl[i].intr, tbl[i].ec, tbl[i].pc, tbl[i].tv, tbl[i].ep,
                     tbl[i].m, tbl[i].delay, 1'(i % 2), tbl[i].exp_pc, tbl[i].exp_cause);

        sleep_seq(10);

        // Reset in the middle of FLUSH: commit pulse and sequence both vanish.
        @(negedge clk);
        traped = 1; interupt = 0; ecause = 4'd4; ecp = 32'h600; mtvec = 32'h2000;
        @(negedge clk);
        traped = 0;
        check("pre_rst_commit", trap_commit, 1);
        rst_n = 0;
        #1;
        check_reset_outputs("midflush_rst");
        m_cause = 0; m_epc = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < FC + 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {29'd0, busy, redirect_valid, flush}, 0);
        end

        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 3);
            r_tv = $urandom;
            r_tv[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) r_tv[1:0] = MTVEC_VECTORED;
            else if ($urandom_range(0, 3) == 0) r_tv[1:0] = MTVEC_DIRECT;
            r_pc = $urandom; r_ep = $urandom;
            r_intr = 1'($urandom_range(0, 1));
            r_ec = r_intr && $urandom_range(0, 1) == 1 ? irq_codes[$urandom_range(0, 2)]
                                                        : 4'($urandom);
            if (kind == 3) begin
                if ($urandom_range(0, 1) == 1) begin
                    sleep_seq($urandom_range(1, 5));
                end else begin
                    @(negedge clk);
                    wfi = 1; irq_pending = 1;
                    @(negedge clk);
                    check("rand_wfi_noop", busy, 0);
                    wfi = 0; irq_pending = 0;
                end
            end else begin
                r_t = (kind != 2);
                r_m = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                do_event(r_t, r_intr, r_ec, r_pc, r_tv, r_ep, r_m, $urandom_range(0, 3),
                         1'($urandom_range(0, 1)),
                         r_t ? model_target(r_tv, r_intr, r_ec) : r_ep,
                         {r_intr, r_ec});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequences pipeline control around the writeback stage's trap, `mret` and `wfi` outcomes. It latches the trap cause and EPC, pulses commit strobes to the CSR file, and holds the pipeline in flush/stall for a fixed drain period. It then hands a redirect PC to fetch over a valid/ready handshake. It sits between writeback, csr, hazard and fetch, and owns the machine-mode sleep state.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` is held after a redirect event; legal range 1..15.

- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `traped`  in  1  trap request from writeback (exception or pending interrupt)
- `interupt`  in  1  trap is an interrupt (qualifies `ecause`)
- `ecause`  in  4  trap cause code
- `ecp`  in  32  exception PC from writeback
- `mret`  in  1  valid `mret` at writeback
- `wfi`  in  1  valid `wfi` at writeback
- `irq_pending`  in  1  any enabled interrupt pending (from csr)
- `mtvec`  in  32  current mtvec CSR
- `mepc`  in  32  current mepc CSR
- `redirect_ready`  in  1  fetch accepts redirect
- `redirect_valid`  out  1  redirect PC offered to fetch
- `redirect_pc`  out  32  redirect target
- `flush`  out  1  kill all in-flight stages
- `stall`  out  1  freeze fetch/decode
- `trap_commit`  out  1  one-cycle pulse: csr latches `trap_epc`/`trap_cause`, enters trap
- `mret_commit`  out  1  one-cycle pulse: csr restores MIE from MPIE
- `trap_cause`  out  5  registered `{interupt, ecause}`
- `trap_epc`  out  32  registered `ecp`
- `busy`  out  1  state != RUN

## Operation
- States: RUN, FLUSH, REDIRECT, SLEEP.
- RUN: event priority is `traped` > `mret` > `wfi`.
  - `traped`: latch `trap_epc`<=`ecp`, `trap_cause`<={`interupt`,`ecause`}, target<=vector; assert `trap_commit` next cycle; go to FLUSH.
  - `mret`: target<=`mepc`; assert `mret_commit` next cycle; go to FLUSH.
  - `wfi` with `irq_pending`=0: go to SLEEP. With `irq_pending`=1: no-op, stay in RUN.
- Vector: base={`mtvec`[31:2],2'b00}. If `mtvec`[1:0]==2'b01 and `interupt`=1, target=base+{`ecause`,2'b00}; otherwise target=base. The sum is 32-bit and wraps modulo 2^32.
- FLUSH: `flush`=1, `stall`=1. A counter loads `FLUSH_CYCLES`-1 on entry and decrements; at 0, go to REDIRECT.
- REDIRECT: `redirect_valid`=1 and `redirect_pc`=target, both held stable until `redirect_ready`. Handshake cycle: go to RUN. `stall`=1 and `flush`=0 in this state.
- SLEEP: `stall`=1, `flush`=0. When `irq_pending`=1, go to RUN. The interrupt is then raised by writeback as `traped`, with EPC = next PC after the `wfi`.
- All of `traped`/`mret`/`wfi` are ignored outside RUN. Interrupt lines can hold `traped` high during the sequence; no re-trigger until RUN.
- `trap_commit` and `mret_commit` are never both high, and each is high at most 1 cycle per event.

## Timing
- Reset: state RUN; all outputs 0; `redirect_pc`, `trap_epc`, `trap_cause`, target and counter all 0.
- Event sampled at edge k in RUN. In cycle k+1: commit pulse, `flush`=`stall`=`busy`=1.
- `flush` is high for exactly `FLUSH_CYCLES` cycles (k+1..k+`FLUSH_CYCLES`).
- `redirect_valid` is first high in cycle k+`FLUSH_CYCLES`+1. With `redirect_ready` tied 1, the block is back in RUN at k+`FLUSH_CYCLES`+2.
- `rst_n` low in any state: immediate return to RUN with reset outputs. No partial commit pulse survives.

## Structure
- Shared package `trap_pkg`:
  - state enum
  - `MTVEC_DIRECT`=2'b00, `MTVEC_VECTORED`=2'b01
  - `CAUSE_W`=5
  - interrupt cause codes: external 11, timer 7, software 3
- Sub-module `trap_vector_calc`: combinational target from `mtvec`, `interupt`, `ecause`. Reused by the csr block for mtvec legality checks.

## Test plan
- Exception, direct mode: `traped`=1, `interupt`=0, `ecause`=2, `ecp`=0x100, `mtvec`=0x8000_0000, ready=1. Expect `trap_commit` at k+1, `trap_cause`=0x02, `trap_epc`=0x100, flush for 2 cycles, `redirect_pc`=0x8000_0000 at k+3.
- Vectored interrupt: `mtvec`=0x8000_0001, `interupt`=1, `ecause`=7. Expect `redirect_pc`=0x8000_001C and `trap_cause`=0x17.
- Simultaneous `traped`+`mret`: expect only `trap_commit`, and the vector target rather than `mepc`.
- `mret`, `mepc`=0x204, `redirect_ready` low 3 cycles: expect `redirect_valid`/`redirect_pc`=0x204 stable throughout, then RUN the cycle after ready.
- `wfi` with `irq_pending`=0: expect SLEEP with `stall`=1. Raise `irq_pending` after 10 cycles: expect RUN next cycle. Repeat `wfi` with `irq_pending`=1: expect no state change.
- `rst_n` pulled low mid-FLUSH: expect all outputs 0 and `busy`=0 immediately, and no redirect after release.
